// File: rtl/icache_refill_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_responder_pkg
// Shared widths, FSM state type and the line-alignment helper used by the
// instruction-cache refill responder and its bus interface.
// -----------------------------------------------------------------------------
package icache_refill_responder_pkg;

  localparam int WORD           = 32;                   // data word width (bits)
  localparam int LINE_WIDTH     = 128;                  // refill line width (bits)
  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD;    // words per refill line
  localparam int LINE_BYTE_LOG  = 4;                    // log2(bytes per line)
  localparam int WORD_BYTES     = WORD / 8;             // address step per word
  localparam int CNT_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Byte address of the first word of the line containing addr.
  function automatic logic [WORD-1:0] line_base(input logic [WORD-1:0] addr);
    return {addr[WORD-1:LINE_BYTE_LOG], {LINE_BYTE_LOG{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_responder_if.sv
// -----------------------------------------------------------------------------
// icache_refill_responder_if
// Bundles the cache-side refill handshake and the instruction-memory read port.
//
// Handshake: the cache raises memory_valid with a stable load_addr and holds it
// until it sees the one-cycle memory_ready pulse (or drops it early on a
// flush). memory_ready means inst_from_mem holds the requested line in that
// same cycle. On the memory side, mem_en/mem_addr issue one read per cycle and
// mem_rdata answers a fixed number of cycles later; the memory cannot stall.
//
// Modports:
//   slave  - responder view (drives memory_ready, inst_from_mem, mem_en, mem_addr)
//   master - cache + memory view (drives memory_valid, load_addr, mem_rdata)
// -----------------------------------------------------------------------------
interface icache_refill_responder_if;
  import icache_refill_responder_pkg::*;

  logic                  memory_valid;
  logic [WORD-1:0]       load_addr;
  logic                  memory_ready;
  logic [LINE_WIDTH-1:0] inst_from_mem;
  logic                  mem_en;
  logic [WORD-1:0]       mem_addr;
  logic [WORD-1:0]       mem_rdata;

  modport slave (
    input  memory_valid, load_addr, mem_rdata,
    output memory_ready, inst_from_mem, mem_en, mem_addr
  );

  modport master (
    output memory_valid, load_addr, mem_rdata,
    input  memory_ready, inst_from_mem, mem_en, mem_addr
  );

endinterface

// File: rtl/icache_refill_responder.sv
// -----------------------------------------------------------------------------
// icache_refill_responder
// Memory-side end of the instruction-cache refill. Accepts a line request,
// issues WORDS_PER_LINE pipelined reads to a fixed-latency memory, assembles
// the returned words into one line and answers with a one-cycle memory_ready.
// A request dropped while reads are outstanding aborts: issuing stops, the
// in-flight words drain, and no ready pulse is produced.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   bus          - refill handshake + memory read port (slave modport)
//   dbg_state_o  - current FSM state
// Parameter:
//   MEM_LATENCY  - cycles from mem_en to valid mem_rdata, 1..4
// -----------------------------------------------------------------------------
module icache_refill_responder
  import icache_refill_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  icache_refill_responder_if.slave    bus,
  output state_e                      dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      cap_cnt_q, cap_cnt_d;
  logic                  abort_q, abort_d;
  logic [WORD-1:0]       mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  ready_q, ready_d;
  // One bit per read in flight; the top bit marks the word arriving this cycle.
  logic [MEM_LATENCY-1:0] pend_q, pend_d;
  logic                  mem_en;
  logic                  capture;
  logic                  drain_done;

  always_comb begin
    mem_en     = (state_q == ST_ISSUE) && bus.memory_valid;
    pend_d     = MEM_LATENCY'({pend_q, mem_en});
    capture    = pend_q[MEM_LATENCY-1];
    // Nothing left in flight once this edge retires the current return.
    drain_done = (pend_d == '0);
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    abort_d     = abort_q;
    mem_addr_d  = mem_addr_q;
    line_d      = line_q;

    // Returns arrive in issue order, so cap_cnt names the destination slot.
    if (capture) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (cap_cnt_q == CNT_W'(k)) line_d[k*WORD +: WORD] = bus.mem_rdata;
      end
      if (cap_cnt_q != CNT_LAST) cap_cnt_d = cap_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.memory_valid) begin
          mem_addr_d  = line_base(bus.load_addr);
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          abort_d     = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.memory_valid) begin
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (issue_cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          mem_addr_d  = mem_addr_q + WORD'(WORD_BYTES);
        end
      end
      ST_DRAIN: begin
        if (!bus.memory_valid) abort_d = 1'b1;
        if (drain_done) state_d = (abort_q || !bus.memory_valid) ? ST_GAP : ST_RESP;
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      abort_q     <= 1'b0;
      mem_addr_q  <= '0;
      line_q      <= '0;
      ready_q     <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      abort_q     <= abort_d;
      mem_addr_q  <= mem_addr_d;
      line_q      <= line_d;
      ready_q     <= ready_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.mem_en        = mem_en;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.memory_ready  = ready_q;
  assign bus.inst_from_mem = line_q;
  assign dbg_state_o       = state_q;

endmodule
